// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I subset: sequences fetch, decode, execute,
// memory and writeback steps and drives datapath enables, selects and the memory handshake.
module multicycle_controller #(
   parameter int MEM_WAIT_MAX = 255,
   parameter int WAIT_W       = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic       func7,
   input  logic       zero,
   input  logic       b31,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_control,
   output logic [2:0] imm_src,
   output logic       retire,
   output logic       halt
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_MEM_ADR, S_MEM_READ,
      S_MEM_WB, S_MEM_WRITE, S_BRANCH, S_JAL_LINK, S_JAL_JUMP, S_JALR_LINK, S_JALR_JUMP, S_HALT
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              halt_q, halt_d;

   logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c, retire_c;
   logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c;
   logic [2:0] alu_control_c, imm_src_c;
   logic [2:0] alu_sel;
   logic       alu_legal, br_taken, br_legal, mem_wait, timeout;

   always_comb begin
      state_d       = state_q;
      mem_req_c     = 1'b0;
      mem_write_c   = 1'b0;
      adr_src_c     = 1'b0;
      ir_write_c    = 1'b0;
      pc_write_c    = 1'b0;
      reg_write_c   = 1'b0;
      retire_c      = 1'b0;
      result_src_c  = 2'b00;
      alu_src_a_c   = 2'b00;
      alu_src_b_c   = 2'b00;
      alu_control_c = ALU_ADD;
      imm_src_c     = IMM_I;

      // func3 -> ALU operation shared by R-type and I-type; sub is layered on in EXEC_R
      alu_legal = 1'b1;
      alu_sel   = ALU_ADD;
      case (func3)
         3'b000:  alu_sel = ALU_ADD;
         3'b111:  alu_sel = ALU_AND;
         3'b110:  alu_sel = ALU_OR;
         3'b100:  alu_sel = ALU_XOR;
         3'b010:  alu_sel = ALU_SLT;
         default: alu_legal = 1'b0;
      endcase

      br_legal = 1'b1;
      br_taken = 1'b0;
      case (func3)
         3'b000:  br_taken = zero;
         3'b001:  br_taken = ~zero;
         3'b100:  br_taken = b31;
         3'b101:  br_taken = ~b31;
         default: br_legal = 1'b0;
      endcase

      case (state_q)
         S_FETCH: begin
            mem_req_c    = 1'b1;
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               state_d    = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            if (op == OP_BR)       imm_src_c = IMM_B;
            else if (op == OP_JAL) imm_src_c = IMM_J;
            case (op)
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_LD, OP_ST: state_d = S_MEM_ADR;
               OP_BR:        state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL_LINK;
               OP_JALR:      state_d = S_JALR_LINK;
               OP_LUI:       state_d = S_LUI;
               default:      state_d = S_HALT;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a_c   = 2'b10;
            alu_control_c = (func3 == 3'b000 && func7) ? ALU_SUB : alu_sel;
            state_d       = alu_legal ? S_ALU_WB : S_HALT;
         end
         S_EXEC_I: begin
            alu_src_a_c   = 2'b10;
            alu_src_b_c   = 2'b01;
            alu_control_c = alu_sel;
            state_d       = alu_legal ? S_ALU_WB : S_HALT;
         end
         S_LUI: begin
            alu_src_a_c = 2'b11;
            alu_src_b_c = 2'b01;
            imm_src_c   = IMM_U;
            state_d     = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            state_d     = S_FETCH;
         end
         S_MEM_ADR: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            imm_src_c   = (op == OP_ST) ? IMM_S : IMM_I;
            if (func3 != 3'b010)  state_d = S_HALT;
            else if (op == OP_ST) state_d = S_MEM_WRITE;
            else                  state_d = S_MEM_READ;
         end
         S_MEM_READ: begin
            mem_req_c = 1'b1;
            adr_src_c = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_src_c = 2'b01;
            reg_write_c  = 1'b1;
            retire_c     = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_req_c   = 1'b1;
            mem_write_c = 1'b1;
            adr_src_c   = 1'b1;
            if (mem_ready) begin
               retire_c = 1'b1;
               state_d  = S_FETCH;
            end
         end
         S_BRANCH: begin
            alu_src_a_c   = 2'b10;
            alu_control_c = ALU_SUB;
            if (br_legal) begin
               pc_write_c = br_taken;
               retire_c   = 1'b1;
               state_d    = S_FETCH;
            end else begin
               state_d = S_HALT;
            end
         end
         S_JAL_LINK: begin
            result_src_c = 2'b11;
            reg_write_c  = 1'b1;
            alu_src_a_c  = 2'b01;
            alu_src_b_c  = 2'b01;
            imm_src_c    = IMM_J;
            state_d      = S_JAL_JUMP;
         end
         S_JAL_JUMP: begin
            pc_write_c = 1'b1;
            retire_c   = 1'b1;
            state_d    = S_FETCH;
         end
         S_JALR_LINK: begin
            result_src_c = 2'b11;
            if (func3 == 3'b000) begin
               reg_write_c = 1'b1;
               state_d     = S_JALR_JUMP;
            end else begin
               state_d = S_HALT;
            end
         end
         S_JALR_JUMP: begin
            // latch A was captured before the link write, so rd == rs1 still jumps via the old rs1
            alu_src_a_c  = 2'b10;
            alu_src_b_c  = 2'b01;
            result_src_c = 2'b10;
            pc_write_c   = 1'b1;
            retire_c     = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase

      mem_wait = (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE) && !mem_ready;
      timeout  = (MEM_WAIT_MAX != 0) && mem_wait && (wait_q == WAIT_LIMIT);
      if (timeout) state_d = S_HALT;

      wait_d = (mem_wait && state_d == state_q) ? wait_q + WAIT_W'(1) : '0;
      halt_d = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         halt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         halt_q  <= halt_d;
      end
   end

   // everything is gated by rst so a falling reset kills writes within the same cycle
   assign mem_req     = rst & mem_req_c;
   assign mem_write   = rst & mem_write_c;
   assign adr_src     = rst & adr_src_c;
   assign ir_write    = rst & ir_write_c;
   assign pc_write    = rst & pc_write_c;
   assign reg_write   = rst & reg_write_c;
   assign retire      = rst & retire_c;
   assign result_src  = rst ? result_src_c  : 2'b00;
   assign alu_src_a   = rst ? alu_src_a_c   : 2'b00;
   assign alu_src_b   = rst ? alu_src_b_c   : 2'b00;
   assign alu_control = rst ? alu_control_c : 3'b000;
   assign imm_src     = rst ? imm_src_c     : 3'b000;
   assign halt        = halt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: each instruction is summarised per transaction
// and compared with counts derived from the instruction class, stall lengths and wait limit.
module tb_multicycle_controller;

   localparam int MAXW = 5;

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] op = '0;
   logic [2:0] func3 = '0;
   logic       func7 = 1'b0, zero = 1'b0, b31 = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, halt;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] alu_control, imm_src;
   logic [18:0] outs;

   int checks = 0;
   int failures = 0;
   int n_instr = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_WAIT_MAX(MAXW), .WAIT_W(3)) dut (
      .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .b31(b31),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
      .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
      .imm_src(imm_src), .retire(retire), .halt(halt)
   );

   assign outs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire,
                  result_src, alu_src_a, alu_src_b, alu_control, imm_src};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Hold reset through one rising edge, then release 1ns after the edge so the next
   // sampled cycle is the first FETCH cycle with a clean wait count.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      check_eq({tag, "_outs"}, {12'b0, outs, halt}, 32'd0);
      @(posedge clk);
      #1;
      check_eq({tag, "_halt"}, {31'b0, halt}, 32'd0);
      rst = 1'b1;
   endtask

   task automatic run_instr(input logic [6:0] i_op, input logic [2:0] i_f3, input logic i_f7,
                            input logic i_z, input logic i_b, input int fs, input int ms);
      int stall_left, n, k_ir, halt_at;
      int c_ir, c_pc, c_rw, c_req, c_mw, c_ret;
      logic [1:0] rw_rs;
      logic [5:0] pc_sel;
      logic [2:0] alu_seen;
      int cls, exp_halt_at, exp_cyc, exp_pc, exp_rw;
      bit f3_ok, is_mem, taken;
      logic [1:0] exp_rs;
      logic [5:0] exp_pcsel;
      logic [2:0] exp_alu;

      stall_left = fs; n = 0; k_ir = -10; halt_at = 0;
      c_ir = 0; c_pc = 0; c_rw = 0; c_req = 0; c_mw = 0; c_ret = 0;
      rw_rs = '0; pc_sel = '0; alu_seen = '0;

      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         if (c == 1) begin
            op = i_op; func3 = i_f3; func7 = i_f7; zero = i_z; b31 = i_b;
         end
         if (mem_req) begin
            if (stall_left > 0) begin
               mem_ready = 1'b0;
               stall_left--;
            end else begin
               mem_ready = 1'b1;
               stall_left = ms;
            end
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         #1;
         n = c;
         if (ir_write) begin
            c_ir++;
            k_ir = c;
            check_eq("fetch_sel", {25'b0, adr_src, alu_src_a, alu_src_b, result_src}, 32'b0_00_10_10);
         end
         if (pc_write) begin
            c_pc++;
            if (!ir_write) pc_sel = {result_src, alu_src_a, alu_src_b};
         end
         if (reg_write) begin
            c_rw++;
            rw_rs = result_src;
         end
         if (mem_req) c_req++;
         if (mem_write) c_mw++;
         if (retire) c_ret++;
         if (c == k_ir + 2) alu_seen = alu_control;
         if (halt) begin
            halt_at = c;
            break;
         end
         if (retire) break;
      end

      case (i_op)
         OP_R:    cls = 0;
         OP_I:    cls = 1;
         OP_LD:   cls = 2;
         OP_ST:   cls = 3;
         OP_BR:   cls = 4;
         OP_JAL:  cls = 5;
         OP_JALR: cls = 6;
         OP_LUI:  cls = 7;
         default: cls = 8;
      endcase
      case (cls)
         0, 1:    f3_ok = (i_f3 == 0 || i_f3 == 7 || i_f3 == 6 || i_f3 == 4 || i_f3 == 2);
         2, 3:    f3_ok = (i_f3 == 2);
         4:       f3_ok = (i_f3 == 0 || i_f3 == 1 || i_f3 == 4 || i_f3 == 5);
         6:       f3_ok = (i_f3 == 0);
         default: f3_ok = 1'b1;
      endcase
      is_mem = (cls == 2 || cls == 3);

      exp_halt_at = 0;
      if (fs > MAXW)                  exp_halt_at = MAXW + 2;
      else if (cls == 8)              exp_halt_at = fs + 3;
      else if (!f3_ok)                exp_halt_at = fs + 4;
      else if (is_mem && ms > MAXW)   exp_halt_at = fs + MAXW + 5;

      n_instr++;
      $display("instr %0d op=%b f3=%0d f7=%0d z=%0d b31=%0d fs=%0d ms=%0d cycles=%0d halt=%0d",
               n_instr, i_op, i_f3, i_f7, i_z, i_b, fs, ms, n, halt);

      if (exp_halt_at != 0) begin
         check_eq("halt_cycle", halt_at, exp_halt_at);
         check_eq("halt_ir", c_ir, (fs > MAXW) ? 0 : 1);
         check_eq("halt_pc", c_pc, (fs > MAXW) ? 0 : 1);
         check_eq("halt_rw", c_rw, 0);
         check_eq("halt_retire", c_ret, 0);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            op = 7'($urandom);
            #1;
            check_eq("halt_sticky", {12'b0, outs, halt}, 32'd1);
         end
         do_reset("halt_clear");
      end else begin
         taken = (cls == 4) && ((i_f3 == 0 && i_z) || (i_f3 == 1 && !i_z) ||
                                (i_f3 == 4 && i_b) || (i_f3 == 5 && !i_b));
         exp_cyc = ((cls == 4) ? 3 : (cls == 2) ? 5 : 4) + fs + (is_mem ? ms : 0);
         exp_pc  = 1 + ((cls == 5 || cls == 6 || taken) ? 1 : 0);
         exp_rw  = (cls == 3 || cls == 4) ? 0 : 1;
         check_eq("cycles", n, exp_cyc);
         check_eq("ir_writes", c_ir, 1);
         check_eq("pc_writes", c_pc, exp_pc);
         check_eq("reg_writes", c_rw, exp_rw);
         check_eq("mem_req_cycles", c_req, fs + 1 + (is_mem ? ms + 1 : 0));
         check_eq("mem_write_cycles", c_mw, (cls == 3) ? ms + 1 : 0);
         check_eq("retires", c_ret, 1);
         check_eq("no_halt", {31'b0, halt}, 32'd0);
         if (exp_rw == 1) begin
            exp_rs = (cls == 2) ? 2'b01 : (cls == 5 || cls == 6) ? 2'b11 : 2'b00;
            check_eq("wb_result_src", rw_rs, exp_rs);
         end
         if (exp_pc == 2) begin
            exp_pcsel = (cls == 4) ? 6'b00_10_00 : (cls == 6) ? 6'b10_10_01 : 6'b00_00_00;
            check_eq("jump_sel", pc_sel, exp_pcsel);
         end
         if (cls == 0 || cls == 1 || cls == 4) begin
            case (i_f3)
               3'd7:    exp_alu = 3'b010;
               3'd6:    exp_alu = 3'b011;
               3'd4:    exp_alu = 3'b100;
               3'd2:    exp_alu = 3'b101;
               default: exp_alu = (cls == 0 && i_f7) ? 3'b001 : 3'b000;
            endcase
            if (cls == 4) exp_alu = 3'b001;
            check_eq("alu_control", alu_seen, exp_alu);
         end
         if (halt) do_reset("unexpected_halt");
      end
   endtask

   initial begin
      int sel, fs, ms, r;
      logic [6:0] rop;

      do_reset("reset");

      // add x3,x1,x2 twice: 4 cycles each
      run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      // lw with three stall cycles in MEM_READ: 8 cycles
      run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, 3);
      // beq taken, beq not taken, blt taken
      run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 1'b0, 0, 0);
      run_instr(OP_BR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_BR, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
      run_instr(OP_JALR, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_LUI, 3'd5, 1'b1, 1'b0, 1'b0, 0, 0);
      run_instr(OP_R, 3'd0, 1'b1, 1'b0, 1'b0, 1, 0);
      // illegal op, then illegal R-type func3
      run_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_R, 3'd3, 1'b0, 1'b0, 1'b0, 0, 0);
      // wait limit boundary: MAXW stall cycles accepted, one more halts
      run_instr(OP_ST, 3'd2, 1'b0, 1'b0, 1'b0, MAXW, MAXW);
      run_instr(OP_R, 3'd0, 1'b0, 1'b0, 1'b0, MAXW + 1, 0);
      run_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1'b0, 0, MAXW + 1);

      // reset in the middle of a stalled store drops mem_write at once
      @(negedge clk);
      op = OP_ST; func3 = 3'd2; mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("sw_hold", {29'b0, mem_req, mem_write, adr_src}, 32'b111);
      #2;
      do_reset("sw_abort");

      for (int t = 0; t < 200; t++) begin
         sel = $urandom_range(0, 8);
         case (sel)
            0: rop = OP_R;
            1: rop = OP_I;
            2: rop = OP_LD;
            3: rop = OP_ST;
            4: rop = OP_BR;
            5: rop = OP_JAL;
            6: rop = OP_JALR;
            7: rop = OP_LUI;
            default: rop = 7'($urandom);
         endcase
         r  = $urandom_range(0, 19);
         fs = (r < 15) ? (r % 4) : (r < 18) ? MAXW : MAXW + 1;
         r  = $urandom_range(0, 19);
         ms = (r < 15) ? (r % 4) : (r < 18) ? MAXW : MAXW + 1;
         run_instr(rop, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fs, ms);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle control FSM for the RV32I subset executed by the team's datapath: R-type, I-type ALU, lw, sw, beq/bne/blt/bge, jal, jalr, lui.
- Sequences each instruction over 3–5 cycles through the shared ALU and a single unified memory port.
- Drives the datapath enables and mux selects, and implements a req/ready handshake to memory.
- Sits beside the datapath, consuming op/func3/func7/zero/b31 from it.

Parameters:
MEM_WAIT_MAX, 255, max consecutive cycles a memory request may wait for mem_ready before HALT; 0 disables the timeout.
WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MEM_WAIT_MAX.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op  in  7  instr[6:0] from the instruction register
func3  in  3  instr[14:12]
func7  in  1  instr[30]
zero  in  1  ALU result == 0
b31  in  1  ALU result bit 31
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory access request
mem_write  out  1  store (valid only with mem_req)
adr_src  out  1  memory address select: 0 = pc, 1 = alu_out
ir_write  out  1  load the instruction register and old_pc
pc_write  out  1  pc <= result bus
reg_write  out  1  regfile rd <= result bus
result_src  out  2  00 alu_out reg, 01 read data, 10 alu_result, 11 pc
alu_src_a  out  2  00 pc, 01 old_pc, 10 rs1 latch A, 11 zero
alu_src_b  out  2  00 rs2 latch, 01 imm_ext, 10 constant 4
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
retire  out  1  one-cycle pulse on the last cycle of each instruction
halt  out  1  sticky error flag

Behaviour:
- Reset (rst=0, asynchronous):
  - state <= FETCH, wait counter <= 0, halt <= 0.
  - All enables and pulses (mem_req, mem_write, ir_write, pc_write, reg_write, retire) are forced to 0 while rst=0.
  - All selects are 0.
- Outputs decode combinationally from the state. Enables in wait states are gated by mem_ready (Mealy).
- States and actions (signals not listed are 0; alu_control = add unless stated):
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, result_src=10.
    - If mem_ready=1: ir_write=1, pc_write=1 (pc <= pc+4), next DECODE.
    - Otherwise remain in FETCH with no writes.
  - DECODE: a=01, b=01, imm_src=B for branch and J for jal. alu_out latches old_pc+imm.
    - Next state by op: 0110011 EXEC_R; 0010011 EXEC_I; 0000011/0100011 MEM_ADR; 1100011 BRANCH; 1101111 JAL_LINK; 1100111 JALR_LINK; 0110111 LUI.
    - Any other op goes to HALT.
  - EXEC_R: a=10, b=00.
    - func3 000 gives add, or sub when func7=1; 111 and; 110 or; 100 xor; 010 slt.
    - Any other func3 goes to HALT; otherwise next ALU_WB.
  - EXEC_I: a=10, b=01, imm_src=I. Same func3 map, func7 ignored (000 is always add). Next ALU_WB.
  - LUI: a=11, b=01, imm_src=U. Next ALU_WB.
  - ALU_WB: result_src=00, reg_write=1, retire=1. Next FETCH.
  - MEM_ADR: a=10, b=01, imm_src = I for lw, S for sw. func3 must be 010, else HALT.
    - lw goes to MEM_READ; sw goes to MEM_WRITE.
  - MEM_READ: mem_req=1, adr_src=1. Advances to MEM_WB on mem_ready=1.
  - MEM_WB: result_src=01, reg_write=1, retire=1. Next FETCH.
  - MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Both are held until mem_ready.
    - On mem_ready=1: retire=1, next FETCH.
  - BRANCH: a=10, b=00, sub, result_src=00, retire=1. Next FETCH.
    - pc_write is asserted when taken: func3 000 zero; 001 !zero; 100 b31; 101 !b31.
    - Any other func3 goes to HALT with no pc_write and no retire.
  - JAL_LINK: result_src=11, reg_write=1 (rd <= pc, i.e. old_pc+4). a=01, b=01, imm_src=J, so alu_out keeps the target. Next JAL_JUMP.
  - JAL_JUMP: result_src=00, pc_write=1, retire=1. Next FETCH.
  - JALR_LINK: func3 must be 000, else HALT.
    - result_src=11, reg_write=1. Next JALR_JUMP.
  - JALR_JUMP: a=10, b=01, imm_src=I, result_src=10, pc_write=1, retire=1. Next FETCH.
    - Latch A still holds the original rs1, so rd==rs1 is handled correctly.
  - HALT: halt=1, all enables 0. Stays here until reset.
- Latency with mem_ready held 1:
  - R, I, lui, sw, jal, jalr: 4 cycles.
  - lw: 5 cycles.
  - Branches: 3 cycles.
- Wait counter:
  - Increments on each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX with mem_ready still 0, the next state is HALT.
- A reset asserted mid-instruction abandons it immediately. No partial writes occur after rst falls.

Test Plan:
- Reset, then release with mem_ready=1 and add x3,x1,x2 (func7=0) → FETCH(ir_write, pc_write), DECODE, EXEC_R(alu_control=000), ALU_WB(reg_write, result_src=00, retire); retire every 4th cycle.
- lw with mem_ready low for 3 cycles in MEM_READ → mem_req=1 and adr_src=1 held 4 cycles; MEM_WB reg_write=1, result_src=01; total 8 cycles.
- beq zero=1, then beq zero=0, then blt b31=1 → pc_write=1, 0, 1 in the BRANCH cycle; 3 cycles each.
- jalr with rd=rs1 → JALR_LINK reg_write with result_src=11; JALR_JUMP pc_write with a=10, b=01, result_src=10.
- op=1111111, then a fresh run with R-type func3=011 → halt=1 sticky and no further writes; rst=0 clears it.
- MEM_WAIT_MAX=5, mem_ready stuck 0 in FETCH → HALT after 5 wait cycles; rst asserted mid-MEM_WRITE drops mem_write immediately.
